// File: rtl/gowin_tl_pkg.sv
// Shared types and constants for the Gowin PCIe TL transmit arbiter.
package gowin_tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_C = 2'd1,
        ST_OWN_R = 2'd2
    } state_t;

    localparam logic SRC_C = 1'b0;
    localparam logic SRC_R = 1'b1;

    localparam int DEF_PCI_DATA_WIDTH = 256;
    localparam int DW_VALID_W         = DEF_PCI_DATA_WIDTH / 32;

    // Completion source wins when it is the only one pending, or on a tie
    // when the request source was served last.
    function automatic logic grant_c(input logic c_pend, input logic r_pend,
                                     input logic last_src);
        return c_pend && (!r_pend || (last_src == SRC_R));
    endfunction

endpackage

// File: rtl/gowin_tl_tx_outreg.sv
// Single-entry output register toward the hard-IP TX port, with hold on
// backpressure and a count of retired end-of-packet beats.
module gowin_tl_tx_outreg
    import gowin_tl_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [DW_VALID_W-1:0] i_valid,
    input  logic                  i_wait,
    output logic                  o_can_load,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [DATA_W-1:0]     o_data,
    output logic [DW_VALID_W-1:0] o_valid,
    output logic [15:0]           o_pkt_cnt
);

    logic                  r_sop;
    logic                  r_eop;
    logic [DATA_W-1:0]     r_data;
    logic [DW_VALID_W-1:0] r_valid;
    logic [15:0]           r_pkt_cnt;
    logic                  w_full;
    logic                  w_retire;

    // Only non-empty beats are ever loaded, so a non-zero valid marks a held beat.
    assign w_full     = (r_valid != '0);
    assign w_retire   = w_full && !i_wait;
    assign o_can_load = !w_full || !i_wait;

    // NOTE: the data register is reset too, because the outputs must read zero during reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= '0;
            r_valid   <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (i_load) begin
                r_sop   <= i_sop;
                r_eop   <= i_eop;
                r_data  <= i_data;
                r_valid <= i_valid;
            end else if (w_retire) begin
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
                r_valid <= '0;
            end
            if (w_retire && r_eop) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign o_sop     = r_sop;
    assign o_eop     = r_eop;
    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: rtl/gowin_tl_tx_arbiter.sv
// Packet-granular arbiter between the completion and request TLP sources,
// feeding the hard-IP TX port through a one-beat output register.
module gowin_tl_tx_arbiter
    import gowin_tl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 256
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        C_SOP,
    input  logic                        C_EOP,
    input  logic [C_PCI_DATA_WIDTH-1:0] C_DATA,
    input  logic [DW_VALID_W-1:0]       C_VALID,
    input  logic                        C_PEND,
    output logic                        C_READY,
    input  logic                        R_SOP,
    input  logic                        R_EOP,
    input  logic [C_PCI_DATA_WIDTH-1:0] R_DATA,
    input  logic [DW_VALID_W-1:0]       R_VALID,
    input  logic                        R_PEND,
    output logic                        R_READY,
    output logic                        TL_TX_SOP,
    output logic                        TL_TX_EOP,
    output logic [C_PCI_DATA_WIDTH-1:0] TL_TX_DATA,
    output logic [DW_VALID_W-1:0]       TL_TX_VALID,
    input  logic                        TL_TX_WAIT,
    output logic [15:0]                 TX_PKT_CNT
);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_last_src;
    logic                          w_last_src_nxt;
    logic                          w_can_load;
    logic                          w_c_xfer;
    logic                          w_r_xfer;
    logic                          w_sel_r;
    logic                          w_sop;
    logic                          w_eop;
    logic [C_PCI_DATA_WIDTH-1:0]   w_data;
    logic [DW_VALID_W-1:0]         w_valid;

    assign C_READY  = (r_state == ST_OWN_C) && w_can_load;
    assign R_READY  = (r_state == ST_OWN_R) && w_can_load;
    assign w_c_xfer = C_READY && (C_VALID != '0);
    assign w_r_xfer = R_READY && (R_VALID != '0);

    assign w_sel_r = (r_state == ST_OWN_R);
    assign w_sop   = w_sel_r ? R_SOP   : C_SOP;
    assign w_eop   = w_sel_r ? R_EOP   : C_EOP;
    assign w_data  = w_sel_r ? R_DATA  : C_DATA;
    assign w_valid = w_sel_r ? R_VALID : C_VALID;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_last_src <= SRC_R;
        end else begin
            r_state    <= w_state_nxt;
            r_last_src <= w_last_src_nxt;
        end
    end

    // PEND is only consulted in IDLE, so a source dropping it mid-packet keeps ownership.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_state_nxt    = r_state;
        w_last_src_nxt = r_last_src;
        case (r_state)
            ST_IDLE: begin
                if (grant_c(C_PEND, R_PEND, r_last_src)) begin
                    w_state_nxt    = ST_OWN_C;
                    w_last_src_nxt = SRC_C;
                end else if (R_PEND) begin
                    w_state_nxt    = ST_OWN_R;
                    w_last_src_nxt = SRC_R;
                end
            end
            ST_OWN_C: if (w_c_xfer && C_EOP) w_state_nxt = ST_IDLE;
            ST_OWN_R: if (w_r_xfer && R_EOP) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    gowin_tl_tx_outreg #(
        .DATA_W (C_PCI_DATA_WIDTH)
    ) u_outreg (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_c_xfer || w_r_xfer),
        .i_sop      (w_sop),
        .i_eop      (w_eop),
        .i_data     (w_data),
        .i_valid    (w_valid),
        .i_wait     (TL_TX_WAIT),
        .o_can_load (w_can_load),
        .o_sop      (TL_TX_SOP),
        .o_eop      (TL_TX_EOP),
        .o_data     (TL_TX_DATA),
        .o_valid    (TL_TX_VALID),
        .o_pkt_cnt  (TX_PKT_CNT)
    );

endmodule

// File: tb/tb_gowin_tl_tx_arbiter.sv
// Scoreboard bench for gowin_tl_tx_arbiter: source queues feed the DUT, the
// expected output order is queued as packets are scheduled.
module tb_gowin_tl_tx_arbiter;

    localparam int DW = 256;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
        logic [7:0]    valid;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          C_SOP = 1'b0, C_EOP = 1'b0, C_PEND = 1'b0;
    logic [DW-1:0] C_DATA = '0;
    logic [7:0]    C_VALID = 8'h00;
    logic          C_READY;
    logic          R_SOP = 1'b0, R_EOP = 1'b0, R_PEND = 1'b0;
    logic [DW-1:0] R_DATA = '0;
    logic [7:0]    R_VALID = 8'h00;
    logic          R_READY;
    logic          TL_TX_SOP, TL_TX_EOP;
    logic [DW-1:0] TL_TX_DATA;
    logic [7:0]    TL_TX_VALID;
    logic          TL_TX_WAIT = 1'b0;
    logic [15:0]   TX_PKT_CNT;

    beat_t       c_q[$];
    beat_t       r_q[$];
    beat_t       exp_q[$];
    beat_t       c_x, r_x, prev_out;
    logic [15:0] exp_cnt = 16'd0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          c_gap = 0;
    int          c_eop_cyc = -1;
    int          r_sop_cyc = -1;
    bit          c_drop_pend = 1'b0;
    bit          c_xfer, r_xfer, prev_held, prev_eop_xfer, own_act, own_src;

    gowin_tl_tx_arbiter #(.C_PCI_DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .C_SOP(C_SOP), .C_EOP(C_EOP), .C_DATA(C_DATA), .C_VALID(C_VALID),
        .C_PEND(C_PEND), .C_READY(C_READY),
        .R_SOP(R_SOP), .R_EOP(R_EOP), .R_DATA(R_DATA), .R_VALID(R_VALID),
        .R_PEND(R_PEND), .R_READY(R_READY),
        .TL_TX_SOP(TL_TX_SOP), .TL_TX_EOP(TL_TX_EOP), .TL_TX_DATA(TL_TX_DATA),
        .TL_TX_VALID(TL_TX_VALID), .TL_TX_WAIT(TL_TX_WAIT), .TX_PKT_CNT(TX_PKT_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] rnd_data(input logic [7:0] tag);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[DW-1 -: 8] = tag;
        return d;
    endfunction

    task automatic add_pkt(input bit src, input int n, input logic [7:0] tag);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.data  = rnd_data(tag + 8'(i));
            b.valid = (i == n - 1) ? (8'hFF >> tag[2:0]) : 8'hFF;
            if (src) r_q.push_back(b);
            else     c_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic idle_inputs();
        C_SOP = 0; C_EOP = 0; C_VALID = 8'h00; C_PEND = 0;
        R_SOP = 0; R_EOP = 0; R_VALID = 8'h00; R_PEND = 0;
        TL_TX_WAIT = 0;
    endtask

    task automatic clear_bench();
        c_q.delete(); r_q.delete(); exp_q.delete();
        exp_cnt = 16'd0; own_act = 0; prev_held = 0; prev_eop_xfer = 0;
        c_gap = 0; c_drop_pend = 0;
        idle_inputs();
    endtask

    // One clock: drive at the falling edge, sample 1 time unit before the rising edge.
    task automatic step(input logic wait_v);
        beat_t exp_b;
        @(negedge CLK);
        TL_TX_WAIT = wait_v;
        if (c_q.size() != 0) begin
            C_SOP = c_q[0].sop; C_EOP = c_q[0].eop; C_DATA = c_q[0].data;
            C_VALID = (c_gap > 0) ? 8'h00 : c_q[0].valid;
            C_PEND = !(c_drop_pend && !c_q[0].sop);
        end else begin
            C_SOP = 0; C_EOP = 0; C_VALID = 8'h00; C_PEND = 0;
        end
        if (r_q.size() != 0) begin
            R_SOP = r_q[0].sop; R_EOP = r_q[0].eop; R_DATA = r_q[0].data;
            R_VALID = r_q[0].valid; R_PEND = 1'b1;
        end else begin
            R_SOP = 0; R_EOP = 0; R_VALID = 8'h00; R_PEND = 0;
        end
        #4;
        cyc++;
        checks++;
        if (TX_PKT_CNT !== exp_cnt) begin
            errors++;
            $display("FAIL pkt_cnt: got %h, expected %h (cycle %0d)", TX_PKT_CNT, exp_cnt, cyc);
        end
        if (TL_TX_VALID === 8'h00) begin
            checks++;
            if ({TL_TX_SOP, TL_TX_EOP} !== 2'b00) begin
                errors++;
                $display("FAIL idle_flags: got sop/eop=%b%b, expected 00", TL_TX_SOP, TL_TX_EOP);
            end
        end
        if (prev_held) begin
            checks++;
            if (TL_TX_SOP !== prev_out.sop || TL_TX_EOP !== prev_out.eop ||
                TL_TX_DATA !== prev_out.data || TL_TX_VALID !== prev_out.valid) begin
                errors++;
                $display("FAIL hold_stable: got valid=%h data=%h, expected valid=%h data=%h",
                         TL_TX_VALID, TL_TX_DATA, prev_out.valid, prev_out.data);
            end
        end
        if (TL_TX_VALID !== 8'h00 && !wait_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got valid=%h data=%h, expected no beat",
                         TL_TX_VALID, TL_TX_DATA);
            end else begin
                exp_b = exp_q.pop_front();
                if (TL_TX_SOP !== exp_b.sop || TL_TX_EOP !== exp_b.eop ||
                    TL_TX_DATA !== exp_b.data || TL_TX_VALID !== exp_b.valid) begin
                    errors++;
                    $display("FAIL out_beat: got sop=%b eop=%b valid=%h data=%h, expected sop=%b eop=%b valid=%h data=%h",
                             TL_TX_SOP, TL_TX_EOP, TL_TX_VALID, TL_TX_DATA,
                             exp_b.sop, exp_b.eop, exp_b.valid, exp_b.data);
                end
                if (exp_b.eop) exp_cnt++;
            end
        end
        prev_held      = (TL_TX_VALID !== 8'h00) && wait_v;
        prev_out.sop   = TL_TX_SOP;
        prev_out.eop   = TL_TX_EOP;
        prev_out.data  = TL_TX_DATA;
        prev_out.valid = TL_TX_VALID;

        c_xfer = (C_READY === 1'b1) && (C_VALID != 8'h00);
        r_xfer = (R_READY === 1'b1) && (R_VALID != 8'h00);
        checks++;
        if (C_READY === 1'b1 && R_READY === 1'b1) begin
            errors++;
            $display("FAIL both_ready: got C_READY=1 R_READY=1, expected at most one");
        end
        if (prev_eop_xfer) begin
            checks++;
            if ({C_READY, R_READY} !== 2'b00) begin
                errors++;
                $display("FAIL idle_bubble: got ready=%b%b, expected 00 after EOP", C_READY, R_READY);
            end
        end
        if (own_act) begin
            checks++;
            if (((own_src == 1'b0) ? R_READY : C_READY) !== 1'b0) begin
                errors++;
                $display("FAIL non_owner_ready: got 1, expected 0 (owner %0d)", own_src);
            end
        end
        prev_eop_xfer = (c_xfer && C_EOP) || (r_xfer && R_EOP);
        if (c_xfer) begin
            c_x = c_q.pop_front();
            if (c_x.sop) begin own_act = 1; own_src = 0; end
            if (c_x.eop) begin own_act = 0; c_eop_cyc = cyc; end
        end
        if (r_xfer) begin
            r_x = r_q.pop_front();
            if (r_x.sop) begin own_act = 1; own_src = 1; r_sop_cyc = cyc; end
            if (r_x.eop) own_act = 0;
        end
        if (c_gap > 0) c_gap--;
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || c_q.size() != 0 || r_q.size() != 0) && n < budget) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || c_q.size() != 0 || r_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
            c_q.delete(); r_q.delete(); exp_q.delete();
        end
        step(1'b0);
        step(1'b0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        clear_bench();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        C_PEND = 1; R_PEND = 1; C_VALID = 8'hFF; R_VALID = 8'hFF;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({C_READY, R_READY, TL_TX_SOP, TL_TX_EOP} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_flags: got %b, expected 0000", {C_READY, R_READY, TL_TX_SOP, TL_TX_EOP});
        end
        checks++;
        if (TL_TX_VALID !== 8'h00 || TL_TX_DATA !== '0) begin
            errors++;
            $display("FAIL reset_beat: got valid=%h data=%h, expected zero", TL_TX_VALID, TL_TX_DATA);
        end
        checks++;
        if (TX_PKT_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt: got %h, expected 0000", TX_PKT_CNT);
        end
        clear_bench();
        RST = 1'b0;
    endtask

    task automatic test_alternate();
        add_pkt(0, 2, 8'h10);
        add_pkt(1, 2, 8'h20);
        add_pkt(0, 2, 8'h11);
        add_pkt(1, 2, 8'h21);
        run_until_done(60, "alternate");
        checks++;
        if (TX_PKT_CNT !== 16'd4) begin
            errors++;
            $display("FAIL alternate_cnt: got %0d, expected 4", TX_PKT_CNT);
        end
    endtask

    task automatic test_wait_hold();
        logic [DW-1:0] held;
        int n = 0;
        add_pkt(1, 3, 8'h30);
        do begin
            step(1'b0);
            n++;
        end while (!(r_xfer && !r_x.sop && !r_x.eop) && n < 20);
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL wait_beat2: got no second beat in 20 cycles, expected transfer");
        end
        held = r_x.data;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            checks++;
            if (TL_TX_DATA !== held || TL_TX_VALID !== 8'hFF || R_READY !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold: got data=%h valid=%h ready=%b, expected data=%h valid=ff ready=0",
                         TL_TX_DATA, TL_TX_VALID, R_READY, held);
            end
        end
        run_until_done(30, "wait");
    endtask

    task automatic test_no_interleave();
        c_drop_pend = 1'b1;
        c_eop_cyc   = -1;
        r_sop_cyc   = -1;
        add_pkt(0, 4, 8'h40);
        step(1'b0);
        add_pkt(1, 2, 8'h50);
        run_until_done(40, "interleave");
        checks++;
        if (r_sop_cyc !== c_eop_cyc + 2) begin
            errors++;
            $display("FAIL r_grant_latency: got R SOP at cycle %0d, expected %0d", r_sop_cyc, c_eop_cyc + 2);
        end
        c_drop_pend = 1'b0;
    endtask

    task automatic test_valid_gaps();
        int n = 0;
        add_pkt(0, 4, 8'h60);
        add_pkt(1, 1, 8'h70);
        do begin
            step(1'b0);
            n++;
        end while (!(c_xfer && !c_x.sop && !c_x.eop) && n < 20);
        c_gap = 3;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            if (i < 3) begin
                checks++;
                if (C_READY !== 1'b1 || R_READY !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_owner: got ready=%b%b, expected 10", C_READY, R_READY);
                end
            end
            if (i >= 1) begin
                checks++;
                if (TL_TX_VALID !== 8'h00) begin
                    errors++;
                    $display("FAIL gap_output: got valid=%h, expected 00", TL_TX_VALID);
                end
            end
        end
        run_until_done(30, "gaps");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        add_pkt(0, 4, 8'h80);
        do begin
            step(1'b0);
            n++;
        end while (!(c_xfer && !c_x.sop && !c_x.eop) && n < 20);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({C_READY, R_READY, TL_TX_SOP, TL_TX_EOP} !== 4'b0000 || TL_TX_VALID !== 8'h00 ||
            TL_TX_DATA !== '0 || TX_PKT_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b%b sop/eop=%b%b valid=%h cnt=%h, expected all zero",
                     C_READY, R_READY, TL_TX_SOP, TL_TX_EOP, TL_TX_VALID, TX_PKT_CNT);
        end
        clear_bench();
        add_pkt(0, 1, 8'hA0);
        add_pkt(1, 1, 8'hA1);
        @(negedge CLK);
        RST = 1'b0;
        run_until_done(20, "post_reset");
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 65535; i++) add_pkt(0, 1, 8'(i));
        run_until_done(140000, "wrap_fill");
        checks++;
        if (TX_PKT_CNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_full: got %h, expected ffff", TX_PKT_CNT);
        end
        add_pkt(1, 1, 8'hC3);
        run_until_done(20, "wrap");
        checks++;
        if (TX_PKT_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h, expected 0000", TX_PKT_CNT);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_wait_hold();
        test_no_interleave();
        test_valid_gaps();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gowin_tl_tx_arbiter.md
GOWIN_TL_TX_ARBITER -- requirements
Module: gowin_tl_tx_arbiter

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 256: TLP beat width in bits; dword-valid width is C_PCI_DATA_WIDTH/32.
REQ-002 SHALL have port CLK, input, 1: single clock, the PCIe TL clock.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports C_SOP/C_EOP, input, 1 each: completion-source start/end of packet.
REQ-005 SHALL have ports C_DATA, input, C_PCI_DATA_WIDTH: completion beat data; C_VALID, input, 8: per-dword valid.
REQ-006 SHALL have port C_PEND, input, 1: completion packet pending; C_READY, output, 1: completion beat accepted when high.
REQ-007 SHALL have ports R_SOP, R_EOP, R_DATA, R_VALID, R_PEND and R_READY, with the same widths and meanings as REQ-004..006, for the request source.
REQ-008 SHALL have ports TL_TX_SOP, TL_TX_EOP (output, 1), TL_TX_DATA (output, C_PCI_DATA_WIDTH) and TL_TX_VALID (output, 8), driving the hard-IP TX port.
REQ-009 SHALL have port TL_TX_WAIT, input, 1: hard-IP backpressure.
REQ-010 SHALL have port TX_PKT_CNT, output, 16: count of packets whose EOP beat left the output.

Function
REQ-011 A beat SHALL transfer from a source when its READY=1 and its VALID is not 8'h00 in the same cycle.
REQ-012 The FSM SHALL have states IDLE, OWN_C and OWN_R.
REQ-013 IDLE SHALL transition as follows:
- only C_PEND set -> OWN_C;
- only R_PEND set -> OWN_R;
- both set -> the source not served last;
- neither set -> stay in IDLE.
REQ-014 OWN_x SHALL return to IDLE on the cycle after the owner's EOP beat transfers; one idle bubble between packets is required.
REQ-015 A packet SHALL never be interleaved: a non-owner's READY SHALL stay 0 for the whole packet.
REQ-016 Owner READY SHALL be 1 iff state is OWN_x and (output stage empty, or TL_TX_WAIT=0).
REQ-017 The output stage SHALL be one register: a transferred beat appears on TL_TX_* the next cycle.
REQ-018 While TL_TX_WAIT=1 with a beat held, TL_TX_* SHALL be held stable.
REQ-019 When no beat is held, TL_TX_VALID SHALL be 8'h00 and TL_TX_SOP/EOP SHALL be 0.
REQ-020 A held beat SHALL retire on any cycle with TL_TX_WAIT=0.
REQ-021 TX_PKT_CNT SHALL increment by 1 when a beat with TL_TX_EOP=1 retires, and SHALL wrap 16'hFFFF -> 0.
REQ-022 An owner beat with VALID=8'h00 SHALL not transfer and SHALL not change state.
REQ-023 SOP/EOP SHALL be forwarded unchecked; a single-beat packet (SOP=EOP=1) SHALL be legal.
REQ-024 Deassertion of C_PEND/R_PEND while that source is owner SHALL be ignored until EOP.

Reset
REQ-025 While RST=1 the block SHALL drive:
- state IDLE;
- all READY=0;
- TL_TX_SOP/EOP=0, TL_TX_DATA=0, TL_TX_VALID=0;
- TX_PKT_CNT=0;
- last-served = request source, so the completion source wins the first tie.
REQ-026 Reset mid-packet SHALL discard the partial packet and the held beat immediately; no truncated-packet recovery is required.

Structure
REQ-027 Package gowin_tl_pkg SHALL hold the FSM state enum, source index constants (SRC_C=0, SRC_R=1) and the dword-valid width constant.
REQ-028 The output register/hold logic SHALL be sub-module gowin_tl_tx_outreg; arbitration and the FSM SHALL stay in the top.

Verification
REQ-029 C_PEND=R_PEND=1 from reset, both sending 2-beat packets -> output order C,R,C,R; one idle cycle between packets; TX_PKT_CNT=4.
REQ-030 TL_TX_WAIT=1 for 5 cycles during beat 2 of a 3-beat R packet -> beat 2 is held stable 5 cycles; R_READY=0 throughout; no beat is lost or duplicated.
REQ-031 C starts a 4-beat packet, R_PEND rises on C beat 1 -> R_READY=0 until C EOP has transferred; R is granted immediately after.
REQ-032 Owner drives VALID=8'h00 for 3 cycles mid-packet -> no output beat in those cycles; state unchanged; the packet completes intact.
REQ-033 RST pulses during beat 2 of a 4-beat packet -> all outputs are 0 immediately; after release, C wins the first tie.
REQ-034 TX_PKT_CNT preloaded to 16'hFFFF via 65535 single-beat packets, then one more -> counter reads 0.
